// File: rtl/display_scan_ctrl.sv
`timescale 1ns / 1ps
// display_scan_ctrl
// Time-multiplexed scanner/driver for an N-digit common-anode seven-segment
// display. A prescaler drives a PWM tick counter, which in turn steps the
// scanned digit. Digit data is double-buffered into shadow registers once per
// frame so a value never changes part-way through a scan.
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 12500,
    parameter int BRIGHT_W   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic [BRIGHT_W-1:0]           brightness,
    output logic [NUM_DIGITS-1:0]         anode,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // "Off" level of each output; XOR with it converts active-high to pin polarity.
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = (ACTIVE_LOW != 0);

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || PRESCALE < 1) begin : g_param_check
            $error("display_scan_ctrl: NUM_DIGITS must be 2..16 and PRESCALE >= 1");
        end
    endgenerate

    // Hex nibble to active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]        pre_cnt;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [IDX_W-1:0]        digit_idx_q;

    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic [BRIGHT_W-1:0]     bright_sh;

    logic [NUM_DIGITS-1:0]   anode_q;
    logic [6:0]              seg_q;
    logic                    dp_q;

    logic                    pre_wrap;
    logic                    pwm_wrap;
    logic                    dig_wrap;
    logic                    lit;
    logic [3:0]              cur_nibble;
    logic [NUM_DIGITS-1:0]   anode_on;

    // Wrap strobes, lit decision and active-high digit selection for the current scan state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        anode_on   = '0;
        pre_wrap   = enable && (pre_cnt == PRE_LAST);
        pwm_wrap   = pre_wrap && (pwm_cnt == '1);
        dig_wrap   = pwm_wrap && (digit_idx_q == IDX_LAST);
        lit        = enable && (pwm_cnt <= bright_sh) && !blank_sh[digit_idx_q];
        cur_nibble = digits_sh[{digit_idx_q, 2'b00} +: 4];
        anode_on[digit_idx_q] = 1'b1;
    end

    // Prescaler -> PWM tick -> digit index chain; everything holds while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            digit_idx_q <= '0;
        end else if (enable) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pre_cnt <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
            if (pre_wrap) pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
            if (pwm_wrap) digit_idx_q <= dig_wrap ? '0 : digit_idx_q + IDX_W'(1);
        end
    end

    // Shadow registers: digit data once per frame, brightness once per slot; both track inputs while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are small flop banks, not RAM, so resetting them costs nothing and avoids X on the pins.
            digits_sh <= '0;
            dp_sh     <= '0;
            blank_sh  <= '0;
            bright_sh <= '0;
        end else begin
            if (!enable || dig_wrap) begin
                digits_sh <= digits_in;
                dp_sh     <= dp_in;
                blank_sh  <= blank_in;
            end
            if (!enable || pwm_wrap) bright_sh <= brightness;
        end
    end

    // Registered pin drivers, one cycle behind the scan state; dark whenever the digit is not lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_q <= ANODE_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
        end else if (lit) begin
            anode_q <= anode_on ^ ANODE_OFF;
            seg_q   <= hex7(cur_nibble) ^ SEG_OFF;
            dp_q    <= dp_sh[digit_idx_q] ^ DP_OFF;
        end else begin
            anode_q <= ANODE_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = dig_wrap;

endmodule

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns / 1ps
// tb_display_scan_ctrl
// Self-checking bench for display_scan_ctrl (4 digits, 8-cycle slot, 32-cycle
// frame). The reference model tracks only the number of enabled cycles since
// reset and derives tick, slot and digit positions from it arithmetically.
module tb_display_scan_ctrl;

    localparam int ND    = 4;
    localparam int PS    = 2;
    localparam int BW    = 2;
    localparam int SLOT  = PS * (1 << BW);
    localparam int FRAME = SLOT * ND;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [1:0]  brightness = '0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS(ND),
        .PRESCALE  (PS),
        .BRIGHT_W  (BW),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .brightness(brightness),
        .anode     (anode),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Active-high gfedcba patterns for 0..F.
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state.
    int          t;          // enabled clock edges since reset
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic [1:0]  m_br;
    logic [14:0] exp_vec;    // {anode, seg, dp, digit_idx, frame_tick}

    task automatic model_reset();
        t       = 0;
        m_dig   = '0;
        m_dp    = '0;
        m_blank = '0;
        m_br    = '0;
    endtask

    // Advance one clock: predict the registered outputs from the pre-edge state, update the model, sample at edge+1.
    task automatic tick();
        int          pwm;
        int          d;
        logic        lit;
        logic [11:0] nxt;
        pwm = (t / PS) % (1 << BW);
        d   = (t / SLOT) % ND;
        lit = enable && (pwm <= int'(m_br)) && !m_blank[d];
        if (lit) nxt = {~(4'b0001 << d), ~hex_tab[m_dig[4*d +: 4]], ~m_dp[d]};
        else     nxt = {4'hF, 7'h7F, 1'b1};
        if (!enable || (t % FRAME == FRAME - 1)) begin
            m_dig   = digits_in;
            m_dp    = dp_in;
            m_blank = blank_in;
        end
        if (!enable || (t % SLOT == SLOT - 1)) m_br = brightness;
        if (enable) t++;
        @(posedge clk);
        #1;
        exp_vec = {nxt, 2'((t / SLOT) % ND), enable && (t % FRAME == FRAME - 1)};
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        digits_in  = 16'h3210;
        dp_in      = '0;
        blank_in   = '0;
        brightness = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({anode, seg, dp, digit_idx, frame_tick} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", {anode, seg, dp, digit_idx, frame_tick},
                     {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        #3 rst_n = 1'b1;
        model_reset();
        tick();  // disabled cycle loads the shadow registers
        n_checks++;
        if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_load: got %h want %h", {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
        end
    endtask

    task automatic test_scan();
        int lit1 = 0;
        int fts  = 0;
        enable = 1'b1;
        repeat (FRAME) begin
            tick();
            n_checks++;
            if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                n_fail++;
                $display("FAIL scan t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
            end
            if (frame_tick) fts++;
            if (anode == 4'b1101) begin
                lit1++;
                n_checks++;
                if (seg !== 7'h79) begin
                    n_fail++;
                    $display("FAIL scan_seg_digit1: got %h want 79", seg);
                end
            end
        end
        n_checks++;
        if (lit1 != SLOT) begin
            n_fail++;
            $display("FAIL scan_digit1_cycles: got %0d want %0d", lit1, SLOT);
        end
        n_checks++;
        if (fts != 1) begin
            n_fail++;
            $display("FAIL scan_frame_ticks: got %0d want 1", fts);
        end
    endtask

    task automatic test_brightness();
        for (int br = 0; br < 2; br++) begin
            int cnt = 0;
            brightness = 2'(br);
            do begin
                tick();
                n_checks++;
                if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                    n_fail++;
                    $display("FAIL bright_align t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
                end
            end while (t % FRAME != 0);
            repeat (FRAME) begin
                tick();
                n_checks++;
                if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                    n_fail++;
                    $display("FAIL bright t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
                end
                if (anode != 4'hF) cnt++;
            end
            n_checks++;
            if (cnt != ND * (br + 1) * PS) begin
                n_fail++;
                $display("FAIL bright_duty br=%0d: lit %0d want %0d", br, cnt, ND * (br + 1) * PS);
            end
        end
    endtask

    task automatic test_blank_dp();
        int lit2 = 0;
        int dps  = 0;
        brightness = 2'd3;
        blank_in   = 4'b0100;
        dp_in      = 4'b0001;
        do tick(); while (t % FRAME != 0);
        repeat (FRAME) begin
            tick();
            n_checks++;
            if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                n_fail++;
                $display("FAIL blank t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
            end
            if (anode == 4'b1011) lit2++;
            if (dp == 1'b0) begin
                dps++;
                n_checks++;
                if (anode !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL dp_owner: anode %b want 1110", anode);
                end
            end
        end
        n_checks++;
        if (lit2 != 0) begin
            n_fail++;
            $display("FAIL blank_digit2: lit %0d want 0", lit2);
        end
        n_checks++;
        if (dps != SLOT) begin
            n_fail++;
            $display("FAIL dp_cycles: got %0d want %0d", dps, SLOT);
        end
    endtask

    task automatic test_frame_load();
        logic [6:0] want;
        blank_in  = '0;
        dp_in     = '0;
        digits_in = 16'h3210;
        do tick(); while (t % FRAME != 0);
        while (t % FRAME != 10) tick();
        digits_in = 16'hABCD;
        do begin
            tick();
            n_checks++;
            if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                n_fail++;
                $display("FAIL load_old t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
            end
            want = (anode == 4'b1101) ? 7'h79 : (anode == 4'b1011) ? 7'h24 : 7'h30;
            if (anode != 4'hF && anode != 4'b1110) begin
                n_checks++;
                if (seg !== want) begin
                    n_fail++;
                    $display("FAIL load_old_seg anode=%b: got %h want %h", anode, seg, want);
                end
            end
        end while (t % FRAME != 0);
        repeat (FRAME) begin
            tick();
            n_checks++;
            if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                n_fail++;
                $display("FAIL load_new t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
            end
            want = (anode == 4'b1110) ? 7'h21 : (anode == 4'b1101) ? 7'h46 :
                   (anode == 4'b1011) ? 7'h03 : 7'h08;
            if (anode != 4'hF) begin
                n_checks++;
                if (seg !== want) begin
                    n_fail++;
                    $display("FAIL load_new_seg anode=%b: got %h want %h", anode, seg, want);
                end
            end
        end
    endtask

    task automatic test_enable_gap();
        logic [1:0] saved_idx;
        int         fts = 0;
        while (t % SLOT != 3) tick();
        saved_idx = digit_idx;
        enable = 1'b0;
        repeat (5) begin
            tick();
            n_checks++;
            if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                n_fail++;
                $display("FAIL gap t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
            end
            n_checks++;
            if (anode !== 4'hF || digit_idx !== saved_idx) begin
                n_fail++;
                $display("FAIL gap_dark_hold: anode %b idx %0d want 1111 idx %0d", anode, digit_idx, saved_idx);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            n_checks++;
            if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                n_fail++;
                $display("FAIL gap_resume t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
            end
            if (frame_tick) fts++;
            if (i == 3) begin
                n_checks++;
                if (digit_idx !== saved_idx) begin
                    n_fail++;
                    $display("FAIL gap_slot_remainder: idx %0d want %0d", digit_idx, saved_idx);
                end
            end
        end
        n_checks++;
        if (fts != 1) begin
            n_fail++;
            $display("FAIL gap_frame_ticks: got %0d want 1", fts);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (t % FRAME != 13) tick();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({anode, seg, dp, digit_idx, frame_tick} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", {anode, seg, dp, digit_idx, frame_tick},
                     {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        end
        #2 rst_n = 1'b1;
        model_reset();
        do begin
            tick();
            n++;
            n_checks++;
            if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                n_fail++;
                $display("FAIL post_reset t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
            end
        end while (!frame_tick && n < 100);
        // frame_tick is expected during the 32nd cycle after release (31 edges).
        n_checks++;
        if (n != FRAME - 1) begin
            n_fail++;
            $display("FAIL post_reset_first_tick: after %0d edges want %0d", n, FRAME - 1);
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) digits_in = 16'($urandom);
            if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) blank_in = 4'($urandom);
            if ($urandom_range(0, 29) == 0) brightness = 2'($urandom);
            tick();
            n_checks++;
            if ({anode, seg, dp, digit_idx, frame_tick} !== exp_vec) begin
                n_fail++;
                $display("FAIL random t=%0d: got %h want %h", t, {anode, seg, dp, digit_idx, frame_tick}, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_brightness();
        test_blank_dp();
        test_frame_load();
        test_enable_gap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
